bridge_gate_driver: RTL

- Downstream stage of the gen/fb selector: consumes its `out` (the phase-reference square wave) and produces the two non-overlapping full-bridge gate commands.
- Gates the bridge with the interrupter enable, inserting dead time at every phase reversal.
- Starts and stops bursts only on phase edges, so switching is at zero-current crossings.
- Enforces a maximum burst length and latches an over-current trip.

---
 rtl/bridge_gate_driver_pkg.sv | 18 +
 rtl/bridge_gate_driver_if.sv | 13 +
 rtl/bridge_gate_driver_dead_time_gen.sv | 45 ++++
 rtl/bridge_gate_driver.sv | 127 ++++++++++++
 4 files changed

// File: rtl/bridge_gate_driver_pkg.sv
// Shared types and parameter derivations for the full-bridge gate driver.
package drv_pkg;

  typedef enum logic [2:0] {IDLE, ARM, RUN, STOP, FAULT} drv_state_t;

  function automatic int calc_max_on_cnt(input int clk_mhz, input int max_on_us);
    return clk_mhz * max_on_us;
  endfunction

  function automatic int calc_stop_cnt(input int clk_mhz, input int timeout_us);
    return clk_mhz * timeout_us;
  endfunction

  function automatic int calc_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bridge_gate_driver_if.sv
// Phase/enable/trip inputs and gate/status outputs of the bridge gate driver.
interface bridge_gate_driver_if;
  logic sig;
  logic intr;
  logic ocd;
  logic gate_a;
  logic gate_b;
  logic active;
  logic fault;

  modport master (output sig, intr, ocd, input gate_a, gate_b, active, fault);
  modport slave  (input sig, intr, ocd, output gate_a, gate_b, active, fault);
endinterface

// File: rtl/bridge_gate_driver_dead_time_gen.sv
// Non-overlapping gate pair with dead time after every strobe.
// strobe clears both gates and restarts the window; en low holds the gates.
module dead_time_gen
  import drv_pkg::*;
#(
  parameter int DEAD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  input  logic phase,
  input  logic en,
  output logic gate_a,
  output logic gate_b
);

  localparam int DW = calc_cnt_w(DEAD_CYCLES);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);

  logic [DW-1:0] dead_cnt;
  logic          phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_cnt <= '0;
      phase_q  <= 1'b0;
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
    end else if (strobe) begin
      dead_cnt <= DEAD_LOAD;
      phase_q  <= phase;
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
    end else begin
      if (dead_cnt != '0) dead_cnt <= dead_cnt - 1'b1;
      if (en && (dead_cnt == '0)) begin
        gate_a <= phase_q;
        gate_b <= !phase_q;
      end
    end
  end

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n) !(gate_a && gate_b));

endmodule

// File: rtl/bridge_gate_driver.sv
// Burst sequencer for the full bridge: arms on intr, switches only on sig edges,
// caps burst length and latches over-current trips.
//   state | meaning
//   IDLE  | gates low, waiting for intr (and intr low after a max-on abort)
//   ARM   | gates low, waiting for the first sig edge
//   RUN   | gates follow phase with dead time at each edge
//   STOP  | gates hold until the closing edge or stop timeout
//   FAULT | gates low, fault set until intr drops
module bridge_gate_driver
  import drv_pkg::*;
#(
  parameter int CLK_MHZ         = 100,
  parameter int DEAD_CYCLES     = 10,
  parameter int MAX_ON_US       = 200,
  parameter int STOP_TIMEOUT_US = 4
) (
  input logic clk,
  input logic rst_n,
  bridge_gate_driver_if.slave bus
);

  localparam int MAX_ON_CNT = calc_max_on_cnt(CLK_MHZ, MAX_ON_US);
  localparam int STOP_CNT   = calc_stop_cnt(CLK_MHZ, STOP_TIMEOUT_US);
  localparam int ON_W       = calc_cnt_w(MAX_ON_CNT);
  localparam int STOP_W     = calc_cnt_w(STOP_CNT);
  localparam logic [ON_W-1:0]   ON_SAT    = ON_W'(MAX_ON_CNT);
  localparam logic [ON_W-1:0]   ON_LAST   = ON_W'(MAX_ON_CNT - 1);
  localparam logic [STOP_W-1:0] STOP_SAT  = STOP_W'(STOP_CNT);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_CNT - 1);

  drv_state_t        state, state_d;
  logic              sig_q, intr_q, ocd_q;
  logic              sig_edge;
  logic [ON_W-1:0]   on_cnt;
  logic [STOP_W-1:0] stop_cnt;
  logic              need_low;
  logic              max_abort;
  logic              active_q, fault_q;
  logic              kill, gate_en;

  assign sig_edge = bus.sig ^ sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q  <= 1'b0;
      intr_q <= 1'b0;
      ocd_q  <= 1'b0;
    end else begin
      sig_q  <= bus.sig;
      intr_q <= bus.intr;
      ocd_q  <= bus.ocd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    max_abort = 1'b0;
    if (ocd_q) begin
      state_d = FAULT;
    end else begin
      case (state)
        IDLE:  if (intr_q && !need_low) state_d = ARM;
        ARM: begin
          if (!intr_q)       state_d = IDLE;
          else if (sig_edge) state_d = RUN;
        end
        RUN: begin
          // A stop request coinciding with an edge is its own closing edge.
          if (!intr_q || (on_cnt == ON_LAST)) begin
            max_abort = (on_cnt == ON_LAST);
            state_d   = sig_edge ? IDLE : STOP;
          end
        end
        STOP:  if (sig_edge || (stop_cnt == STOP_LAST)) state_d = IDLE;
        FAULT: if (!intr_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_cnt   <= '0;
      stop_cnt <= '0;
      need_low <= 1'b0;
      active_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      if ((state_d == ARM) && (state != ARM))           on_cnt <= '0;
      else if ((state == RUN) && (on_cnt != ON_SAT))    on_cnt <= on_cnt + 1'b1;

      if ((state_d == STOP) && (state != STOP))         stop_cnt <= '0;
      else if ((state == STOP) && (stop_cnt != STOP_SAT)) stop_cnt <= stop_cnt + 1'b1;

      if (!intr_q)        need_low <= 1'b0;
      else if (max_abort) need_low <= 1'b1;

      active_q <= (state_d == ARM) || (state_d == RUN) || (state_d == STOP);
      fault_q  <= (state_d == FAULT);
    end
  end

  // Any state without a live half-cycle forces the gates low via the strobe.
  assign kill    = (state_d != RUN) && (state_d != STOP);
  assign gate_en = (state_d == RUN);

  dead_time_gen #(
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_dead (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (sig_edge | kill),
    .phase  (bus.sig),
    .en     (gate_en),
    .gate_a (bus.gate_a),
    .gate_b (bus.gate_b)
  );

  assign bus.active = active_q;
  assign bus.fault  = fault_q;

endmodule
